// File: rtl/hazard_control_unit_if.sv
// Hazard unit bundle: pipeline hazard sources in, stall/flush controls out.
// master drives the pipeline side, slave is the hazard unit.
interface hazard_control_unit_if;
  logic [3:0]  id_rs;
  logic [3:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        ex_memRead;
  logic [3:0]  ex_rd;
  logic        branch_taken;
  logic        mem_busy;
  logic        id_halt;
  logic        resume;

  logic        pc_write;
  logic        stall_ifid;
  logic        flush_ifid;
  logic        stall_idex;
  logic        flush_idex;
  logic        stall_back;
  logic        halted;
  logic        fault;
  logic [2:0]  state;
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt,
    output ex_memRead, ex_rd,
    output branch_taken, mem_busy, id_halt, resume,
    input  pc_write, stall_ifid, flush_ifid,
    input  stall_idex, flush_idex, stall_back,
    input  halted, fault, state,
    input  stall_cycles, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  ex_memRead, ex_rd,
    input  branch_taken, mem_busy, id_halt, resume,
    output pc_write, stall_ifid, flush_ifid,
    output stall_idex, flush_idex, stall_back,
    output halted, fault, state,
    output stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use bubbles, branch flushes,
// memory-wait freeze with timeout fault, and HALT drain/resume.
module hazard_control_unit #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  hazard_control_unit_if.slave  hz
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    DRAIN    = 3'd2,
    HALTED   = 3'd3,
    FAULT    = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]  drain_cnt_q, drain_cnt_d;
  logic [15:0] stall_q, stall_d;
  logic [15:0] flush_q, flush_d;

  logic load_use;
  logic rs_hit;
  logic rt_hit;
  logic pc_write;
  logic stall_ifid;
  logic flush_ifid;
  logic stall_idex;
  logic flush_idex;
  logic stall_back;
  logic halted;
  logic fault;

  assign rs_hit = hz.id_uses_rs && (hz.id_rs == hz.ex_rd);
  assign rt_hit = hz.id_uses_rt && (hz.id_rt == hz.ex_rd);
  assign load_use = hz.ex_memRead && (hz.ex_rd != 4'd0)
                 && (rs_hit || rt_hit);

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    drain_cnt_d = drain_cnt_q;
    pc_write    = 1'b1;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    stall_idex  = 1'b0;
    flush_idex  = 1'b0;
    stall_back  = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;

    unique case (state_q)
      RUN, MEM_WAIT: begin
        if (hz.mem_busy) begin
          pc_write   = 1'b0;
          stall_ifid = 1'b1;
          stall_idex = 1'b1;
          stall_back = 1'b1;
          if (state_q == RUN) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = 8'd1;
          end else if (wait_cnt_q == 8'(WAIT_LIMIT)) begin
            state_d = FAULT;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
          if (hz.branch_taken) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (load_use) begin
            pc_write   = 1'b0;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (hz.id_halt) begin
            pc_write    = 1'b0;
            stall_ifid  = 1'b1;
            flush_idex  = 1'b1;
            state_d     = DRAIN;
            drain_cnt_d = 2'd3;
          end
        end
      end

      DRAIN: begin
        pc_write   = 1'b0;
        stall_ifid = 1'b1;
        if (hz.mem_busy) begin
          stall_idex = 1'b1;
          stall_back = 1'b1;
        end else begin
          flush_idex = 1'b1;
          // A zero count here would mean we are already drained
          if (drain_cnt_q <= 2'd1) begin
            drain_cnt_d = 2'd0;
            state_d     = HALTED;
          end else begin
            drain_cnt_d = drain_cnt_q - 2'd1;
          end
        end
      end

      HALTED: begin
        halted     = 1'b1;
        flush_idex = 1'b1;
        if (hz.resume) begin
          flush_ifid = 1'b1;
          state_d    = RUN;
        end else begin
          pc_write   = 1'b0;
          stall_ifid = 1'b1;
        end
      end

      FAULT: begin
        fault      = 1'b1;
        pc_write   = 1'b0;
        stall_ifid = 1'b1;
        stall_idex = 1'b1;
        stall_back = 1'b1;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_write && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
    if (flush_ifid && (flush_q != 16'hFFFF)) begin
      flush_d = flush_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      drain_cnt_q <= 2'd0;
      stall_q     <= 16'd0;
      flush_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.stall_ifid   = stall_ifid;
  assign hz.flush_ifid   = flush_ifid;
  assign hz.stall_idex   = stall_idex;
  assign hz.flush_idex   = flush_idex;
  assign hz.stall_back   = stall_back;
  assign hz.halted       = halted;
  assign hz.fault        = fault;
  assign hz.state        = state_q;
  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: directed scenarios
// followed by randomized traffic against a behavioural model.
module tb_hazard_control_unit;

  localparam int WL = 15;

  localparam logic [7:0] C_IDLE   = 8'h80;
  localparam logic [7:0] C_FREEZE = 8'h54;
  localparam logic [7:0] C_FAULT  = 8'h55;
  localparam logic [7:0] C_BRANCH = 8'hA8;
  localparam logic [7:0] C_BUBBLE = 8'h48;
  localparam logic [7:0] C_HALT   = 8'h4A;
  localparam logic [7:0] C_RESUME = 8'hAA;

  typedef struct packed {
    logic [3:0] rs;
    logic [3:0] rt;
    logic       urs;
    logic       urt;
    logic       mr;
    logic [3:0] rd;
    logic       br;
    logic       busy;
    logic       halt;
    logic       resume;
  } in_t;

  typedef struct packed {
    logic [7:0]  ctl;
    logic [2:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  hazard_control_unit_if hz ();

  hazard_control_unit #(.WAIT_LIMIT(WL)) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz.slave)
  );

  always #5 clock = ~clock;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // model: mode uses the documented state numbers
  int m_st;
  int m_busy_run;
  int m_drain_left;
  int m_sc;
  int m_fc;

  task automatic model_reset();
    m_st = 0;
    m_busy_run = 0;
    m_drain_left = 0;
    m_sc = 0;
    m_fc = 0;
  endtask

  task automatic model_step(input in_t s, output exp_t e);
    bit lu;
    logic [7:0] c;
    int nxt;
    lu = s.mr && (s.rd != 4'd0) &&
         ((s.urs && s.rs == s.rd) || (s.urt && s.rt == s.rd));
    c = C_IDLE;
    nxt = m_st;
    if (m_st == 4) begin
      c = C_FAULT;
    end else if (m_st == 3) begin
      c = s.resume ? C_RESUME : C_HALT;
      nxt = s.resume ? 0 : 3;
    end else if (s.busy) begin
      c = C_FREEZE;
      if (m_st != 2) begin
        m_busy_run++;
        nxt = (m_busy_run > WL) ? 4 : 1;
      end
    end else if (m_st == 2) begin
      c = C_BUBBLE;
      m_drain_left--;
      nxt = (m_drain_left == 0) ? 3 : 2;
    end else begin
      m_busy_run = 0;
      nxt = 0;
      if (s.br) c = C_BRANCH;
      else if (lu) c = C_BUBBLE;
      else if (s.halt) begin
        c = C_BUBBLE;
        nxt = 2;
        m_drain_left = 3;
      end
    end
    e.ctl = c;
    e.st = 3'(m_st);
    e.sc = 16'(m_sc);
    e.fc = 16'(m_fc);
    if (!c[7] && m_sc < 65535) m_sc++;
    if (c[5] && m_fc < 65535) m_fc++;
    if (nxt != 1 && nxt != 4) m_busy_run = (nxt == 0 && s.busy) ? m_busy_run : 0;
    m_st = nxt;
  endtask

  task automatic apply(input in_t s);
    hz.id_rs        = s.rs;
    hz.id_rt        = s.rt;
    hz.id_uses_rs   = s.urs;
    hz.id_uses_rt   = s.urt;
    hz.ex_memRead   = s.mr;
    hz.ex_rd        = s.rd;
    hz.branch_taken = s.br;
    hz.mem_busy     = s.busy;
    hz.id_halt      = s.halt;
    hz.resume       = s.resume;
  endtask

  task automatic step(input in_t s, input bit rst_n);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst_n;
    if (!rst_n) begin
      apply('0);
      model_reset();
      e.ctl = C_IDLE;
      e.st = 3'd0;
      e.sc = 16'd0;
      e.fc = 16'd0;
    end else begin
      apply(s);
      model_step(s, e);
    end
    q.push_back(e);
  endtask

  function automatic in_t idle();
    return '0;
  endfunction

  function automatic in_t ld_use(input logic [3:0] rd);
    in_t s;
    s = '0;
    s.mr = 1'b1;
    s.rd = rd;
    s.rs = 4'd3;
    s.urs = 1'b1;
    return s;
  endfunction

  function automatic in_t busy();
    in_t s;
    s = '0;
    s.busy = 1'b1;
    return s;
  endfunction

  initial begin : monitor
    exp_t e;
    exp_t g;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        g.ctl = {hz.pc_write, hz.stall_ifid, hz.flush_ifid,
                 hz.stall_idex, hz.flush_idex, hz.stall_back,
                 hz.halted, hz.fault};
        g.st = hz.state;
        g.sc = hz.stall_cycles;
        g.fc = hz.flush_count;
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got ctl=%b st=%0d sc=%0d fc=%0d exp ctl=%b st=%0d sc=%0d fc=%0d",
                   $time, g.ctl, g.st, g.sc, g.fc, e.ctl, e.st, e.sc, e.fc);
        end
        checks++;
        if ((hz.stall_ifid && hz.flush_ifid) ||
            (hz.stall_idex && hz.flush_idex)) begin
          errors++;
          $display("FAIL exclusive t=%0t got ctl=%b exp no stall+flush pair",
                   $time, g.ctl);
        end
      end
    end
  end

  initial begin : stim
    in_t s;
    int burst;
    apply('0);
    model_reset();
    reset = 1'b0;
    step(idle(), 1'b0);
    step(idle(), 1'b0);
    step(idle(), 1'b1);

    step(ld_use(4'd3), 1'b1);
    step(idle(), 1'b1);
    step(ld_use(4'd0), 1'b1);
    step(idle(), 1'b1);

    s = ld_use(4'd3);
    s.br = 1'b1;
    step(s, 1'b1);
    step(idle(), 1'b1);

    repeat (15) step(busy(), 1'b1);
    step(idle(), 1'b1);
    step(idle(), 1'b1);

    s = idle();
    s.halt = 1'b1;
    step(s, 1'b1);
    step(idle(), 1'b1);
    step(busy(), 1'b1);
    step(busy(), 1'b1);
    step(idle(), 1'b1);
    step(idle(), 1'b1);
    step(idle(), 1'b1);
    step(busy(), 1'b1);
    s = idle();
    s.resume = 1'b1;
    step(s, 1'b1);
    step(idle(), 1'b1);

    repeat (16) step(busy(), 1'b1);
    step(idle(), 1'b1);
    step(ld_use(4'd3), 1'b1);
    repeat (4) step(idle(), 1'b1);
    step(idle(), 1'b0);
    step(idle(), 1'b1);

    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      s.rs     = 4'($urandom_range(0, 3));
      s.rt     = 4'($urandom_range(0, 3));
      s.rd     = 4'($urandom_range(0, 3));
      s.urs    = 1'($urandom_range(0, 1));
      s.urt    = 1'($urandom_range(0, 1));
      s.mr     = 1'($urandom_range(0, 1));
      s.br     = ($urandom_range(0, 5) == 0);
      s.halt   = ($urandom_range(0, 39) == 0);
      s.resume = ($urandom_range(0, 3) == 0);
      if (burst == 0 && $urandom_range(0, 7) == 0)
        burst = $urandom_range(1, 18);
      s.busy = (burst > 0);
      if (burst > 0) burst--;
      step(s, ($urandom_range(0, 299) != 0));
    end

    step(idle(), 1'b1);
    repeat (2) @(posedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15, max consecutive memory-busy cycles tolerated (range 1..255).
REQ-002 SHALL have ports: clock  in  1  single clock, all state updates on posedge; reset  in  1  asynchronous, active-low.
REQ-003 SHALL have ports: id_rs, id_rt  in  4 each  source register fields of instruction in IF/ID; id_uses_rs, id_uses_rt  in  1 each  field valid.
REQ-004 SHALL have ports: ex_memRead  in  1  ID/EX holds a load; ex_rd  in  4  load destination.
REQ-005 SHALL have ports: branch_taken  in  1  EX resolved taken branch/jump; mem_busy  in  1  data memory wait; id_halt  in  1  HALT in IF/ID; resume  in  1  restart pulse.
REQ-006 SHALL have ports: pc_write, stall_ifid, flush_ifid, stall_idex, flush_idex, stall_back  out  1 each  pipeline controls (stall_back freezes EX/MEM and MEM/WB).
REQ-007 SHALL have ports: halted, fault  out  1 each; state  out  3; stall_cycles, flush_count  out  16 each.

Function
REQ-008 SHALL implement states RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3, FAULT=4; control outputs are combinational from state and current inputs.
REQ-009 SHALL define load_use = ex_memRead & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
REQ-010 SHALL, in RUN/MEM_WAIT/DRAIN with mem_busy=1, assert freeze: pc_write=0, stall_ifid=1, stall_idex=1, stall_back=1, all flushes 0; other inputs ignored that cycle.
REQ-011 SHALL, in RUN or MEM_WAIT with mem_busy=0, apply priority branch_taken > load_use > id_halt > none.
REQ-012 SHALL, on branch_taken: pc_write=1, flush_ifid=1, flush_idex=1, stalls 0; stay/return RUN.
REQ-013 SHALL, on load_use: pc_write=0, stall_ifid=1, flush_idex=1; one bubble per cycle load_use holds.
REQ-014 SHALL, on id_halt: pc_write=0, stall_ifid=1, flush_idex=1; next state DRAIN with drain_cnt=3.
REQ-015 SHALL, with no event: pc_write=1, all stalls/flushes 0.
REQ-016 SHALL transition RUN->MEM_WAIT when mem_busy=1, loading wait_cnt (8-bit) to 1.
REQ-017 SHALL, in MEM_WAIT with mem_busy=1: if wait_cnt==WAIT_LIMIT go FAULT, else wait_cnt++; with mem_busy=0 go RUN (per REQ-011 outputs that cycle).
REQ-018 SHALL, in DRAIN: pc_write=0, stall_ifid=1, flush_idex=1; drain_cnt decrements only when mem_busy=0; when drain_cnt reaches 0 next state HALTED.
REQ-019 SHALL, in HALTED: halted=1, pc_write=0, stall_ifid=1, flush_idex=1; on resume=1: pc_write=1, flush_ifid=1, stall_ifid=0, next RUN.
REQ-020 SHALL, in FAULT: fault=1, pc_write=0, all stalls 1, flushes 0; sticky until reset; all inputs ignored.
REQ-021 SHALL never assert stall_ifid and flush_ifid together, nor stall_idex and flush_idex together.
REQ-022 SHALL increment stall_cycles each cycle pc_write=0 and flush_count each cycle flush_ifid=1, both saturating at 16'hFFFF.
REQ-023 SHALL drive state output with current state encoding.

Reset
REQ-024 SHALL, on reset low, asynchronously set state=RUN, wait_cnt=0, drain_cnt=0, stall_cycles=0, flush_count=0; control outputs then follow RUN decoding (idle inputs: pc_write=1, rest 0, halted=0, fault=0).
REQ-025 SHALL abort any state (including FAULT, mid-MEM_WAIT, mid-DRAIN) on reset with no residual counts.

Verification
REQ-026 Load-use: ex_memRead=1, ex_rd=3, id_rs=3, id_uses_rs=1 one cycle -> pc_write=0, stall_ifid=1, flush_idex=1, stall_cycles=1; ex_rd=0 same case -> no stall.
REQ-027 Branch+load_use same cycle -> flush_ifid=1, flush_idex=1, pc_write=1, flush_count=1, no stall.
REQ-028 mem_busy 15 cycles then 0 -> freeze 15 cycles, state back to RUN, fault=0; mem_busy 16 cycles -> state=4, fault=1 until reset.
REQ-029 id_halt with mem_busy=1 for 2 cycles during DRAIN -> halted=1 after 1+3+2 cycles; resume -> flush_ifid=1, pc_write=1, state=0.
REQ-030 Reset asserted in FAULT with stall_cycles=20 -> immediately state=0, fault=0, stall_cycles=0, pc_write=1.
